// File: rtl/font_row_fetch.sv
// font_row_fetch: fetches one glyph row from a 1-bit-wide font ROM, one
// pixel per cycle, assembles it into a GLYPH_W-bit word and applies the
// underline and invert attributes before handing it to the consumer.
module font_row_fetch #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int CHAR_BITS    = 7,
  parameter int READ_LATENCY = 1,
  parameter int UL_ROW       = GLYPH_H - 2,
  localparam int RB          = $clog2(GLYPH_H),
  localparam int CB          = $clog2(GLYPH_W),
  localparam int AW          = CHAR_BITS + RB + CB
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CHAR_BITS-1:0] req_char_i,
  input  logic [RB:0]          req_row_i,
  input  logic [1:0]           req_attr_i,
  output logic [AW-1:0]        rom_ad_o,
  output logic                 rom_ce_o,
  output logic                 rom_oce_o,
  input  logic                 rom_dout_i,
  output logic                 row_valid_o,
  input  logic                 row_ready_i,
  output logic [GLYPH_W-1:0]   row_data_o
);

  // Drain counter needs at least one bit even when the ROM has a single cycle of latency
  localparam int DW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [RB:0] UL_ROW_V = (RB + 1)'(UL_ROW);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t                   state_q, state_d;
  logic [CB-1:0]            colCnt_q, colCnt_d;
  logic [DW-1:0]            drainCnt_q, drainCnt_d;
  logic [CHAR_BITS-1:0]     char_q, char_d;
  logic [RB:0]              row_q, row_d;
  logic [1:0]               attr_q, attr_d;
  logic [AW-1:0]            romAd_q, romAd_d;
  logic [GLYPH_W-1:0]       rowBits_q, rowBits_d;
  logic [READ_LATENCY-1:0]  fetchPipe_q, fetchPipe_d;

  logic                     accept;
  logic                     captureEn;
  logic [GLYPH_W-1:0]       ulMask;
  logic [GLYPH_W-1:0]       invMask;

  // State register; reset drops any row in flight and returns to IDLE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: request latch, column/drain counters, ROM address, row shifter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      colCnt_q    <= '0;
      drainCnt_q  <= '0;
      char_q      <= '0;
      row_q       <= '0;
      attr_q      <= '0;
      romAd_q     <= '0;
      rowBits_q   <= '0;
      fetchPipe_q <= '0;
    end else begin
      colCnt_q    <= colCnt_d;
      drainCnt_q  <= drainCnt_d;
      char_q      <= char_d;
      row_q       <= row_d;
      attr_q      <= attr_d;
      romAd_q     <= romAd_d;
      rowBits_q   <= rowBits_d;
      fetchPipe_q <= fetchPipe_d;
    end
  end

  // Next-state and output logic; a bit read in FETCH cycle k lands in the
  // shifter READ_LATENCY+1 edges later, tracked by the fetch pipe
  always_comb begin
    state_d     = state_q;
    colCnt_d    = colCnt_q;
    drainCnt_d  = drainCnt_q;
    char_d      = char_q;
    row_d       = row_q;
    attr_d      = attr_q;
    romAd_d     = romAd_q;
    rowBits_d   = rowBits_q;
    fetchPipe_d = '0;

    req_ready_o = (state_q == IDLE) && !reset_i;
    accept      = req_valid_i && req_ready_o;
    rom_ce_o    = (state_q == FETCH) || (state_q == DRAIN);
    rom_oce_o   = (READ_LATENCY == 2) ? rom_ce_o : 1'b0;
    row_valid_o = (state_q == OUT);

    fetchPipe_d[0] = (state_q == FETCH);
    for (int i = 1; i < READ_LATENCY; i++) begin
      fetchPipe_d[i] = fetchPipe_q[i-1];
    end
    captureEn = fetchPipe_q[READ_LATENCY-1];

    if (captureEn) begin
      rowBits_d = {rom_dout_i, rowBits_q[GLYPH_W-1:1]};
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          char_d    = req_char_i;
          row_d     = req_row_i;
          attr_d    = req_attr_i;
          rowBits_d = '0;
          if (req_row_i[RB]) begin
            state_d = OUT;
          end else begin
            state_d  = FETCH;
            colCnt_d = '0;
            romAd_d  = {req_char_i, req_row_i[RB-1:0], CB'(0)};
          end
        end
      end
      FETCH: begin
        if (colCnt_q == CB'(GLYPH_W - 1)) begin
          state_d    = DRAIN;
          colCnt_d   = '0;
          drainCnt_d = '0;
        end else begin
          colCnt_d = colCnt_q + CB'(1);
          romAd_d  = {char_q, row_q[RB-1:0], colCnt_q + CB'(1)};
        end
      end
      DRAIN: begin
        if (drainCnt_q == DW'(READ_LATENCY - 1)) begin
          state_d = OUT;
        end else begin
          drainCnt_d = drainCnt_q + DW'(1);
        end
      end
      OUT: begin
        if (row_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Attribute masks and the row word presented while in OUT
  always_comb begin
    ulMask     = (attr_q[1] && (row_q == UL_ROW_V)) ? '1 : '0;
    invMask    = attr_q[0] ? '1 : '0;
    row_data_o = '0;
    if (state_q == OUT) begin
      row_data_o = (rowBits_q | ulMask) ^ invMask;
    end
  end

  assign rom_ad_o = romAd_q;

endmodule
